rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between three requesters: pipeline writeback (wb), multi-cycle load return (ld) and debug/scan write (dbg).
- Arbitrates among them with fixed priority for wb, round robin between ld and dbg, and starvation override for ld and dbg.
- Registers the winning write and drives the register file's DstReg/WriteReg/DstData/disable_bypass inputs.
- Sits between the writeback stage and the register file.

Parameters:
- STARVE_LIMIT, 8: consecutive blocked cycles after which ld/dbg overrides wb priority; legal range 1..255.
- ZERO_REG_PROTECT, 1: when 1, accepted writes to R0 complete the handshake but never assert rf_write_reg.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- wb_valid  input  1  writeback request
- wb_ready  output  1  wb request accepted this cycle
- wb_reg  input  4  wb destination register
- wb_data  input  16  wb write data
- ld_valid  input  1  load-return request
- ld_ready  output  1  ld accepted this cycle
- ld_reg  input  4  ld destination register
- ld_data  input  16  ld write data
- dbg_valid  input  1  debug write request
- dbg_ready  output  1  dbg accepted this cycle
- dbg_reg  input  4  dbg destination register
- dbg_data  input  16  dbg write data
- rf_dst_reg  output  4  register file DstReg
- rf_write_reg  output  1  register file WriteReg
- rf_dst_data  output  16  register file DstData
- rf_disable_bypass  output  1  register file disable_bypass
- grant_src  output  2  source of the current rf write: 0 none, 1 wb, 2 ld, 3 dbg

Behaviour:
- Handshake: a transfer occurs when x_valid && x_ready.
  - x_ready is combinational from all valids, the starve counters and rr_ptr.
  - At most one ready is high per cycle.
  - A requester holds valid, reg and data stable until accepted.
- Grant order, evaluated each cycle:
  1. A starved requester (counter == STARVE_LIMIT) wins. If both ld and dbg are starved, rr_ptr chooses.
  2. Otherwise wb wins if valid.
  3. Otherwise ld/dbg round robin by rr_ptr. A sole valid requester wins regardless of rr_ptr.
- rr_ptr: 1 bit, reset points to ld. After an ld or dbg grant it points to the other one. Unchanged on wb grant or idle.
- Starve counters: one each for ld and dbg, 8 bits.
  - Increment when valid && !ready, saturating at STARVE_LIMIT.
  - Clear on grant or when valid is low.
- Output stage, registered, latency 1. On the cycle after acceptance:
  - rf_write_reg = 1, except 0 when ZERO_REG_PROTECT=1 and the register is 0.
  - rf_dst_reg and rf_dst_data carry the accepted reg and data.
  - grant_src = source code.
  - rf_disable_bypass = 1 only for a dbg write.
- With no acceptance: rf_write_reg = 0, grant_src = 0, rf_disable_bypass = 0; rf_dst_reg and rf_dst_data hold their last values.
- Back-to-back: one write per cycle, sustained.
- Same register targeted by several requesters in one cycle: only the winner writes. The loser writes later, so the final register value follows grant order.
- Reset, asynchronous:
  - All outputs go to 0 immediately: rf_* = 0, grant_src = 0, all ready = 0 while rst is high.
  - Counters go to 0 and rr_ptr points to ld.
  - A write registered but not yet presented is dropped.
- First grant is possible in the first cycle after rst deasserts.

Test Plan:
- wb_valid=1 (reg 3, 0xBEEF), ld_valid=1 (reg 3, 0x1234) in the same cycle -> wb_ready=1, ld_ready=0. Next cycle: rf_write_reg=1, rf_dst_reg=3, rf_dst_data=0xBEEF, grant_src=1. ld is granted the following cycle, so R3 ends at 0x1234.
- ld and dbg both valid continuously, wb idle -> grants alternate ld, dbg, ld, dbg starting with ld after reset. dbg writes show rf_disable_bypass=1, ld writes show 0.
- wb_valid held high continuously with ld_valid=1, STARVE_LIMIT=8 -> ld blocked for exactly 8 cycles, ld_ready=1 in cycle 9, wb_ready=0 in that cycle, and the counter clears.
- dbg write to reg 0 (0xFFFF), ZERO_REG_PROTECT=1 -> dbg_ready=1, next cycle grant_src=3 but rf_write_reg=0. With ZERO_REG_PROTECT=0 -> rf_write_reg=1.
- Accept a wb write, then assert rst in the next cycle before the clock edge -> rf_write_reg drops to 0 asynchronously and the write is lost. After release, rr_ptr=ld and both counters=0.
- No requests for 10 cycles -> rf_write_reg=0, grant_src=0, rf_dst_reg/rf_dst_data hold their previous values.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the register file's single write port between pipeline writeback
// (wb), load return (ld) and debug write (dbg). wb has fixed priority, ld and
// dbg alternate round robin, and an ld/dbg requester that has been blocked
// STARVE_LIMIT consecutive cycles overrides wb. The winning write is
// registered and presented to the register file one cycle after acceptance.
module rf_write_arbiter #(
  parameter int unsigned STARVE_LIMIT     = 8,
  parameter bit          ZERO_REG_PROTECT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [3:0]  wb_reg,
  input  logic [15:0] wb_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [3:0]  ld_reg,
  input  logic [15:0] ld_data,
  input  logic        dbg_valid,
  output logic        dbg_ready,
  input  logic [3:0]  dbg_reg,
  input  logic [15:0] dbg_data,
  output logic [3:0]  rf_dst_reg,
  output logic        rf_write_reg,
  output logic [15:0] rf_dst_data,
  output logic        rf_disable_bypass,
  output logic [1:0]  grant_src
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_LD   = 2'd2,
    SRC_DBG  = 2'd3
  } src_e;

  // rr_ptr: 0 favours ld, 1 favours dbg
  logic        rr_ptr_q, rr_ptr_d;
  logic [7:0]  ld_cnt_q, ld_cnt_d;
  logic [7:0]  dbg_cnt_q, dbg_cnt_d;

  logic [3:0]  dst_reg_q, dst_reg_d;
  logic [15:0] dst_data_q, dst_data_d;
  logic        write_q, write_d;
  logic        bypass_q, bypass_d;
  src_e        src_q, src_d;

  src_e        win_s;
  logic        ld_starved_s, dbg_starved_s;
  logic [3:0]  sel_reg_s;
  logic [15:0] sel_data_s;

  assign ld_starved_s  = ld_valid  && (ld_cnt_q  == LIMIT);
  assign dbg_starved_s = dbg_valid && (dbg_cnt_q == LIMIT);

  // Grant selection: starvation override, then wb priority, then round robin.
  // Nothing is granted while reset is asserted.
  always_comb begin
    win_s = SRC_NONE;
    if (rst) begin
      win_s = SRC_NONE;
    end else if (ld_starved_s && dbg_starved_s) begin
      win_s = rr_ptr_q ? SRC_DBG : SRC_LD;
    end else if (ld_starved_s) begin
      win_s = SRC_LD;
    end else if (dbg_starved_s) begin
      win_s = SRC_DBG;
    end else if (wb_valid) begin
      win_s = SRC_WB;
    end else if (ld_valid && dbg_valid) begin
      win_s = rr_ptr_q ? SRC_DBG : SRC_LD;
    end else if (ld_valid) begin
      win_s = SRC_LD;
    end else if (dbg_valid) begin
      win_s = SRC_DBG;
    end else begin
      win_s = SRC_NONE;
    end
  end

  assign wb_ready  = (win_s == SRC_WB);
  assign ld_ready  = (win_s == SRC_LD);
  assign dbg_ready = (win_s == SRC_DBG);

  // Next-state for round-robin pointer, starve counters and the output stage.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    ld_cnt_d   = ld_cnt_q;
    dbg_cnt_d  = dbg_cnt_q;
    sel_reg_s  = 4'd0;
    sel_data_s = 16'd0;

    case (win_s)
      SRC_WB:  begin sel_reg_s = wb_reg;  sel_data_s = wb_data;  end
      SRC_LD:  begin sel_reg_s = ld_reg;  sel_data_s = ld_data;  rr_ptr_d = 1'b1; end
      SRC_DBG: begin sel_reg_s = dbg_reg; sel_data_s = dbg_data; rr_ptr_d = 1'b0; end
      default: begin sel_reg_s = 4'd0;    sel_data_s = 16'd0;    end
    endcase

    // A counter only runs while its requester waits; it saturates at the limit.
    if (!ld_valid || (win_s == SRC_LD)) begin
      ld_cnt_d = 8'd0;
    end else if (ld_cnt_q != LIMIT) begin
      ld_cnt_d = ld_cnt_q + 8'd1;
    end else begin
      ld_cnt_d = ld_cnt_q;
    end

    if (!dbg_valid || (win_s == SRC_DBG)) begin
      dbg_cnt_d = 8'd0;
    end else if (dbg_cnt_q != LIMIT) begin
      dbg_cnt_d = dbg_cnt_q + 8'd1;
    end else begin
      dbg_cnt_d = dbg_cnt_q;
    end

    src_d    = win_s;
    bypass_d = (win_s == SRC_DBG);
    if (win_s != SRC_NONE) begin
      // Writes to R0 still complete the handshake but may be suppressed here.
      write_d    = !(ZERO_REG_PROTECT && (sel_reg_s == 4'd0));
      dst_reg_d  = sel_reg_s;
      dst_data_d = sel_data_s;
    end else begin
      write_d    = 1'b0;
      dst_reg_d  = dst_reg_q;
      dst_data_d = dst_data_q;
    end
  end

  // State and output registers; reset drops any write not yet presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= 1'b0;
      ld_cnt_q   <= 8'd0;
      dbg_cnt_q  <= 8'd0;
      dst_reg_q  <= 4'd0;
      dst_data_q <= 16'd0;
      write_q    <= 1'b0;
      bypass_q   <= 1'b0;
      src_q      <= SRC_NONE;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      ld_cnt_q   <= ld_cnt_d;
      dbg_cnt_q  <= dbg_cnt_d;
      dst_reg_q  <= dst_reg_d;
      dst_data_q <= dst_data_d;
      write_q    <= write_d;
      bypass_q   <= bypass_d;
      src_q      <= src_d;
    end
  end

  assign rf_dst_reg        = dst_reg_q;
  assign rf_dst_data       = dst_data_q;
  assign rf_write_reg      = write_q;
  assign rf_disable_bypass = bypass_q;
  assign grant_src         = src_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: the stimulus thread pushes the
// hand-computed register-file write it expects, a monitor pops and compares
// whenever the DUT presents a write.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0, ld_valid = 1'b0, dbg_valid = 1'b0;
  logic [3:0]  wb_reg = 4'd0, ld_reg = 4'd0, dbg_reg = 4'd0;
  logic [15:0] wb_data = 16'd0, ld_data = 16'd0, dbg_data = 16'd0;

  logic        wb_ready, ld_ready, dbg_ready;
  logic [3:0]  rf_dst_reg;
  logic        rf_write_reg;
  logic [15:0] rf_dst_data;
  logic        rf_disable_bypass;
  logic [1:0]  grant_src;

  logic        n_wb_ready, n_ld_ready, n_dbg_ready;
  logic [3:0]  n_dst_reg;
  logic        n_write_reg;
  logic [15:0] n_dst_data;
  logic        n_bypass;
  logic [1:0]  n_grant_src;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0]  src;
    logic [3:0]  rg;
    logic [15:0] data;
    logic        we;
    logic        byp;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] rf_model [16];

  rf_write_arbiter #(.STARVE_LIMIT(8), .ZERO_REG_PROTECT(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_reg(dbg_reg), .dbg_data(dbg_data),
    .rf_dst_reg(rf_dst_reg), .rf_write_reg(rf_write_reg), .rf_dst_data(rf_dst_data),
    .rf_disable_bypass(rf_disable_bypass), .grant_src(grant_src)
  );

  // Second instance without R0 protection, driven by the same stimulus
  rf_write_arbiter #(.STARVE_LIMIT(8), .ZERO_REG_PROTECT(1'b0)) u_nzp (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(n_wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
    .ld_valid(ld_valid), .ld_ready(n_ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .dbg_valid(dbg_valid), .dbg_ready(n_dbg_ready), .dbg_reg(dbg_reg), .dbg_data(dbg_data),
    .rf_dst_reg(n_dst_reg), .rf_write_reg(n_write_reg), .rf_dst_data(n_dst_data),
    .rf_disable_bypass(n_bypass), .grant_src(n_grant_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] src, input logic [3:0] rg, input logic [15:0] data,
                      input logic we, input logic byp);
    exp_t e;
    e.src = src; e.rg = rg; e.data = data; e.we = we; e.byp = byp;
    sb_q.push_back(e);
  endtask

  // Check the readies mid-cycle, then advance to just after the next edge
  task automatic step(input logic e_wb, input logic e_ld, input logic e_dbg, input string tag);
    @(negedge clk);
    chk({tag, "_wb_ready"},  32'(wb_ready),  32'(e_wb));
    chk({tag, "_ld_ready"},  32'(ld_ready),  32'(e_ld));
    chk({tag, "_dbg_ready"}, 32'(dbg_ready), 32'(e_dbg));
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented write against the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      if (grant_src != 2'd0) begin
        if (sb_q.size() == 0) begin
          chk("mon_unexpected_write", 32'(grant_src), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("mon_grant_src", 32'(grant_src),         32'(e.src));
          chk("mon_dst_reg",   32'(rf_dst_reg),        32'(e.rg));
          chk("mon_dst_data",  32'(rf_dst_data),       32'(e.data));
          chk("mon_write_reg", 32'(rf_write_reg),      32'(e.we));
          chk("mon_bypass",    32'(rf_disable_bypass), 32'(e.byp));
          if (rf_write_reg) rf_model[rf_dst_reg] = rf_dst_data;
        end
      end else begin
        chk("mon_idle_write_reg", 32'(rf_write_reg),      32'd0);
        chk("mon_idle_bypass",    32'(rf_disable_bypass), 32'd0);
      end
    end
  end

  // Watchdog: the directed sequence is short, so this only fires on a hang
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) rf_model[i] = 16'd0;

    // Reset: outputs zero and no ready even with a request pending
    #1 rst = 1'b1;
    #1 wb_valid = 1'b1;
    #1;
    chk("rst_wb_ready",     32'(wb_ready),     32'd0);
    chk("rst_write_reg",    32'(rf_write_reg), 32'd0);
    chk("rst_grant_src",    32'(grant_src),    32'd0);
    chk("rst_dst_reg",      32'(rf_dst_reg),   32'd0);
    chk("rst_dst_data",     32'(rf_dst_data),  32'd0);
    wb_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // wb beats ld on the same register; ld follows, so R3 ends at 0x1234
    wb_valid = 1'b1; wb_reg = 4'd3; wb_data = 16'hBEEF;
    ld_valid = 1'b1; ld_reg = 4'd3; ld_data = 16'h1234;
    push(2'd1, 4'd3, 16'hBEEF, 1'b1, 1'b0);
    push(2'd2, 4'd3, 16'h1234, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, "prio_c1");
    wb_valid = 1'b0;
    step(1'b0, 1'b1, 1'b0, "prio_c2");
    ld_valid = 1'b0;

    // dbg write to R0: handshake completes, write suppressed only when protected
    dbg_valid = 1'b1; dbg_reg = 4'd0; dbg_data = 16'hFFFF;
    push(2'd3, 4'd0, 16'hFFFF, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, "zr");
    dbg_valid = 1'b0;
    chk("zr_nzp_write_reg", 32'(n_write_reg), 32'd1);
    chk("zr_nzp_grant_src", 32'(n_grant_src), 32'd3);

    // wb held high starves ld for exactly 8 cycles, ld wins on the 9th
    wb_valid = 1'b1; wb_reg = 4'd2;
    ld_valid = 1'b1; ld_reg = 4'd5; ld_data = 16'h5555;
    for (int i = 1; i <= 8; i++) begin
      wb_data = 16'h1000 + 16'(i);
      push(2'd1, 4'd2, wb_data, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, "starve_blk");
    end
    wb_data = 16'h1009;
    push(2'd2, 4'd5, 16'h5555, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, "starve_win");
    ld_valid = 1'b0;
    chk("starve_cnt_clear", 32'(u_dut.ld_cnt_q), 32'd0);
    push(2'd1, 4'd2, 16'h1009, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, "starve_after");
    wb_valid = 1'b0;

    // Idle: no write, last destination and data held
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, "idle");
      chk("idle_write_reg", 32'(rf_write_reg), 32'd0);
      chk("idle_grant_src", 32'(grant_src),    32'd0);
      chk("idle_dst_reg",   32'(rf_dst_reg),   32'd2);
      chk("idle_dst_data",  32'(rf_dst_data),  32'h1009);
    end

    // Reset right after an acceptance drops the registered write
    wb_valid = 1'b1; wb_reg = 4'd7;
    ld_valid = 1'b1; ld_reg = 4'd8; ld_data = 16'h8888;
    wb_data = 16'h7777; push(2'd1, 4'd7, 16'h7777, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, "rstw_c1");
    wb_data = 16'h7778; push(2'd1, 4'd7, 16'h7778, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, "rstw_c2");
    wb_data = 16'h7779;
    step(1'b1, 1'b0, 1'b0, "rstw_c3");
    rst = 1'b1;
    #1;
    chk("rstw_write_reg", 32'(rf_write_reg),      32'd0);
    chk("rstw_grant_src", 32'(grant_src),         32'd0);
    chk("rstw_dst_reg",   32'(rf_dst_reg),        32'd0);
    chk("rstw_dst_data",  32'(rf_dst_data),       32'd0);
    chk("rstw_bypass",    32'(rf_disable_bypass), 32'd0);
    chk("rstw_wb_ready",  32'(wb_ready),          32'd0);
    chk("rstw_ld_ready",  32'(ld_ready),          32'd0);
    wb_valid = 1'b0; ld_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstw_ld_cnt",  32'(u_dut.ld_cnt_q),  32'd0);
    chk("rstw_dbg_cnt", 32'(u_dut.dbg_cnt_q), 32'd0);
    chk("rstw_rr_ptr",  32'(u_dut.rr_ptr_q),  32'd0);

    // ld and dbg together alternate starting with ld; dbg disables bypass
    ld_valid  = 1'b1; ld_reg  = 4'd9;  ld_data  = 16'h9001;
    dbg_valid = 1'b1; dbg_reg = 4'd10; dbg_data = 16'hA001;
    push(2'd2, 4'd9, 16'h9001, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, "alt1");
    ld_data = 16'h9002;
    push(2'd3, 4'd10, 16'hA001, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, "alt2");
    dbg_data = 16'hA002;
    push(2'd2, 4'd9, 16'h9002, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, "alt3");
    push(2'd3, 4'd10, 16'hA002, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, "alt4");
    ld_valid = 1'b0; dbg_valid = 1'b0;

    step(1'b0, 1'b0, 1'b0, "drain");
    step(1'b0, 1'b0, 1'b0, "drain");
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("r3_final", 32'(rf_model[3]), 32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
